// File: rtl/pulse_catch.sv
// Captures one-clock nonzero data pulses into a small circular buffer.
// Each falling edge of the rd level signal consumes the oldest word.
module pulse_catch #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N-1:0]               pulse,
    input  logic                       rd,
    output logic [N-1:0]               out,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_q;

    logic          push_req;
    logic          pop_req;
    logic          do_push;
    logic          do_pop;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          ovf_nxt;
    logic [N-1:0]  out_nxt;

    // Request decode: a pop on an empty buffer is ignored, a push on a full
    // buffer only survives when a pop frees a slot at the same edge.
    always_comb begin
        push_req = |pulse;
        pop_req  = rd_q & ~rd;
        do_pop   = pop_req && (count != '0);
        do_push  = push_req && ((count != FULL_CNT) || do_pop);
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        ovf_nxt    = ovf | (push_req & ~do_push);

        if (do_push) begin
            wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Head word after this edge; the only way the head slot is being written
    // right now is when the incoming word lands in an otherwise empty buffer.
    always_comb begin
        out_nxt = '0;
        if (count_nxt != '0) begin
            if (do_push && (wr_ptr == rd_ptr_nxt)) begin
                out_nxt = pulse;
            end else begin
                out_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_q   <= 1'b0;
            count  <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
            out    <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            rd_q   <= rd;
            count  <= count_nxt;
            valid  <= (count_nxt != '0);
            ovf    <= ovf_nxt;
            out    <= out_nxt;
        end
    end

    // Storage is never reset; stale words are masked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= pulse;
        end
    end

endmodule

// File: tb/tb_pulse_catch.sv
// Directed and randomized checks of pulse_catch against a queue-based model.
module tb_pulse_catch;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  pulse;
    logic          rd;
    logic [N-1:0]  out;
    logic          valid;
    logic [CW-1:0] count;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] q [$];
    logic         ovf_m = 1'b0;
    logic         rdq_m = 1'b0;

    pulse_catch #(.N(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pulse   (pulse),
        .rd      (rd),
        .out     (out),
        .valid   (valid),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Model: a falling rd consumes the head if any, then a nonzero pulse is
    // appended if there is room, otherwise it is dropped and ovf latches.
    task automatic model_edge(input logic [N-1:0] p, input logic r);
        if (rdq_m && !r && q.size() != 0) void'(q.pop_front());
        if (p != '0) begin
            if (q.size() < DEPTH) q.push_back(p);
            else ovf_m = 1'b1;
        end
        rdq_m = r;
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0]  eo;
        logic [CW-1:0] ec;
        eo = (q.size() != 0) ? q[0] : '0;
        ec = CW'(q.size());
        checks++;
        assert (out === eo) else begin
            errors++; $error("FAIL %s out got %h want %h", tag, out, eo);
        end
        checks++;
        assert (valid === (q.size() != 0)) else begin
            errors++; $error("FAIL %s valid got %b want %b", tag, valid, q.size() != 0);
        end
        checks++;
        assert (count === ec) else begin
            errors++; $error("FAIL %s count got %0d want %0d", tag, count, ec);
        end
        checks++;
        assert (ovf === ovf_m) else begin
            errors++; $error("FAIL %s ovf got %b want %b", tag, ovf, ovf_m);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ((out === '0) && (valid === 1'b0) && (count === '0) && (ovf === 1'b0)) else begin
            errors++;
            $error("FAIL %s out/valid/count/ovf got %h/%b/%0d/%b want 00/0/0/0",
                   tag, out, valid, count, ovf);
        end
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] want_out,
                              input logic [CW-1:0] want_cnt);
        checks++;
        assert ((out === want_out) && (count === want_cnt)) else begin
            errors++;
            $error("FAIL %s out/count got %h/%0d want %h/%0d",
                   tag, out, count, want_out, want_cnt);
        end
    endtask

    // Called at a falling clock edge; inputs settle long before the next rise.
    task automatic step(input string tag, input logic [N-1:0] p, input logic r);
        pulse = p;
        rd    = r;
        @(posedge clk);
        model_edge(p, r);
        @(negedge clk);
        check_all(tag);
        pulse = '0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 check_zero(tag);
        q.delete();
        ovf_m = 1'b0;
        rdq_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        pulse   = '0;
        rd      = 1'b1;
        #12 check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Single capture, with rd held high through reset causing no pop.
        step("first", 8'h5A, 1'b1);
        expect_out("first_lit", 8'h5A, 3'd1);
        step("drain5a", 8'h00, 1'b0);

        // Fill, then overflow.
        for (int i = 1; i <= 4; i++) step("fill", N'(i), 1'b0);
        expect_out("full_lit", 8'h01, 3'd4);
        step("ovf", 8'h05, 1'b0);
        checks++;
        assert (ovf === 1'b1) else begin
            errors++; $error("FAIL ovf_lit got %b want 1", ovf);
        end

        // rd high 2, low 3, four times: one pop per falling edge.
        for (int k = 0; k < 4; k++) begin
            step("rd_hi", 8'h00, 1'b1);
            step("rd_hi", 8'h00, 1'b1);
            step("rd_lo", 8'h00, 1'b0);
            step("rd_lo", 8'h00, 1'b0);
            step("rd_lo", 8'h00, 1'b0);
        end
        expect_out("drained_lit", 8'h00, 3'd0);

        // Simultaneous push and pop on a full buffer.
        for (int i = 1; i <= 4; i++) step("refill", N'(i), 1'b0);
        step("arm", 8'h00, 1'b1);
        step("full_pp", 8'hAA, 1'b0);
        expect_out("full_pp_lit", 8'h02, 3'd4);
        for (int k = 0; k < 3; k++) begin
            step("pop_hi", 8'h00, 1'b1);
            step("pop_lo", 8'h00, 1'b0);
        end
        expect_out("aa_lit", 8'hAA, 3'd1);
        step("pop_hi", 8'h00, 1'b1);
        step("pop_lo", 8'h00, 1'b0);

        // Simultaneous push and pop on an empty buffer, then an empty pop.
        step("arm", 8'h00, 1'b1);
        step("empty_pp", 8'h33, 1'b0);
        expect_out("empty_pp_lit", 8'h33, 3'd1);
        step("pop_hi", 8'h00, 1'b1);
        step("pop_lo", 8'h00, 1'b0);
        step("pop_hi", 8'h00, 1'b1);
        step("underflow", 8'h00, 1'b0);
        expect_out("underflow_lit", 8'h00, 3'd0);

        // Pointer wrap with interleaved pops, then reset mid-stream.
        for (int i = 0; i < 6; i++) step("wrap", N'(8'h10 + i), 1'(i % 2));
        for (int i = 0; i < 4; i++) step("wrap2", N'(8'h20 + i), 1'(i % 2));
        do_reset("rst_mid");
        step("post_rst", 8'h00, 1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [N-1:0] p;
            p = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset("rst_rand");
            step("rand", p, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
